// File: rtl/dmem_lane_ctrl_if.sv
// dmem_lane_ctrl_if: datapath load/store request side plus word-memory req/ack side.
// slave is the controller's view; master is the view of whoever drives requests and models memory.
interface dmem_lane_ctrl_if;
    logic        memreq;
    logic        memw;
    logic [3:0]  byteenable;
    logic        signedld;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        memdone;
    logic        membusy;
    logic        memfault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    modport slave (
        input  memreq, memw, byteenable, signedld, adr, writedata, mem_rdata, mem_ack,
        output readdata, memdone, membusy, memfault, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output memreq, memw, byteenable, signedld, adr, writedata, mem_rdata, mem_ack,
        input  readdata, memdone, membusy, memfault, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl: load/store lane steering, load extension and byte/half read-modify-write
// in front of a word-only memory, with misalignment and ack-timeout faults.
module dmem_lane_ctrl #(
    parameter int TIMEOUT = 255
) (
    input logic            clk,
    input logic            reset,
    dmem_lane_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, FAULT} state_t;
    state_t      state, state_n;
    logic [31:0] adr_q, wdata_q, old_q;
    logic [3:0]  be_q;
    logic        memw_q, sgn_q;
    logic [15:0] cnt;
    logic        accept, bad, tout;
    logic [3:0]  be_sh;
    logic [31:0] m, wsh, sh_b, sh_h, ext;
    assign accept = state == IDLE && bus.memreq;
    assign bad = !(bus.byteenable == 4'b0001 || bus.byteenable == 4'b0011 || bus.byteenable == 4'b1111)
               || (bus.byteenable == 4'b0011 && bus.adr[0])
               || (bus.byteenable == 4'b1111 && bus.adr[1:0] != 2'b00);
    assign tout = !bus.mem_ack && cnt == 16'(TIMEOUT - 1);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = !bus.memreq ? IDLE : bad ? FAULT
                           : (bus.memw && bus.byteenable == 4'b1111) ? WRITE : READ;
            READ:  state_n = bus.mem_ack ? (memw_q ? WRITE : DONE) : tout ? FAULT : READ;
            WRITE: state_n = bus.mem_ack ? DONE : tout ? FAULT : WRITE;
            default: state_n = IDLE;
        endcase
    end
    // Store merge: shift the right-justified data into its lanes and keep the rest of the old word
    assign be_sh = be_q << adr_q[1:0];
    assign m     = {{8{be_sh[3]}}, {8{be_sh[2]}}, {8{be_sh[1]}}, {8{be_sh[0]}}};
    assign wsh   = wdata_q << {adr_q[1:0], 3'b000};
    assign sh_b  = bus.mem_rdata >> {adr_q[1:0], 3'b000};
    assign sh_h  = bus.mem_rdata >> {adr_q[1], 4'b0000};
    assign ext   = be_q == 4'b1111 ? bus.mem_rdata
                 : be_q == 4'b0011 ? {{16{sgn_q & sh_h[15]}}, sh_h[15:0]}
                 : {{24{sgn_q & sh_b[7]}}, sh_b[7:0]};
    assign bus.mem_req   = state == READ || state == WRITE;
    assign bus.mem_we    = state == WRITE;
    assign bus.mem_addr  = {adr_q[31:2], 2'b00};
    assign bus.mem_wdata = be_q == 4'b1111 ? wdata_q : (old_q & ~m) | (wsh & m);
    assign bus.memdone   = state == DONE || state == FAULT;
    assign bus.memfault  = state == FAULT;
    assign bus.membusy   = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            adr_q        <= '0;
            wdata_q      <= '0;
            old_q        <= '0;
            be_q         <= '0;
            memw_q       <= 1'b0;
            sgn_q        <= 1'b0;
            cnt          <= '0;
            bus.readdata <= '0;
        end else begin
            state <= state_n;
            cnt   <= (bus.mem_req && !bus.mem_ack) ? cnt + 16'd1 : '0;
            if (accept) begin
                adr_q   <= bus.adr;
                wdata_q <= bus.writedata;
                be_q    <= bus.byteenable;
                memw_q  <= bus.memw;
                sgn_q   <= bus.signedld;
            end
            if (state == READ && bus.mem_ack) begin
                old_q <= bus.mem_rdata;
                if (!memw_q) bus.readdata <= ext;
            end
        end
    end
endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// tb_dmem_lane_ctrl: directed scenarios against a small word-memory model with
// hand-computed expected load results, merged store words and completion latencies.
module tb_dmem_lane_ctrl;
    localparam int TO = 8;
    logic clk, reset, ack_en;
    logic [31:0] mem [0:1023];
    int errors, checks, rd_cnt, wr_cnt, req_cnt;
    logic [31:0] last_raddr, last_waddr, last_wdata;

    dmem_lane_ctrl_if bus();
    dmem_lane_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_ack   = ack_en & bus.mem_req;
    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

    always @(posedge clk) begin
        if (bus.mem_req) req_cnt <= req_cnt + 1;
        if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
            wr_cnt <= wr_cnt + 1; last_waddr <= bus.mem_addr; last_wdata <= bus.mem_wdata;
        end
        if (bus.mem_req && bus.mem_ack && !bus.mem_we) begin
            rd_cnt <= rd_cnt + 1; last_raddr <= bus.mem_addr;
        end
    end

    task automatic issue(input logic w, input logic [3:0] be, input logic s, input logic [31:0] a, input logic [31:0] d);
        bus.memreq = 1'b1; bus.memw = w; bus.byteenable = be; bus.signedld = s; bus.adr = a; bus.writedata = d;
        @(posedge clk); #1;
        bus.memreq = 1'b0; bus.memw = ~w; bus.byteenable = 4'b0110; bus.signedld = ~s;
        bus.adr = 32'hFFFF_FFFF; bus.writedata = 32'h0BAD_F00D;
    endtask

    // lat counts clock edges from the accept edge up to the edge that raised memdone; p is memdone one cycle later
    task automatic wait_done(output int lat, output logic f, output logic [31:0] rd, output logic p);
        lat = 1;
        while (!bus.memdone && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!bus.memdone) lat = -1;
        f = bus.memfault; rd = bus.readdata;
        @(posedge clk); #1;
        p = bus.memdone;
    endtask

    task automatic test_reset;
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata got %h want 0", bus.readdata); end
        checks++; if ({bus.memdone, bus.membusy, bus.memfault, bus.mem_req, bus.mem_we} !== 5'b0) begin
            errors++; $display("FAIL rst_flags got %b want 00000", {bus.memdone, bus.membusy, bus.memfault, bus.mem_req, bus.mem_we}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            errors++; $display("FAIL rst_bus got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
    endtask

    task automatic test_load_byte;
        int lat, r0; logic f, p; logic [31:0] rd;
        mem[32'h100 >> 2] = 32'hAABBCCDD;
        r0 = rd_cnt;
        issue(1'b0, 4'b0001, 1'b0, 32'h102, 32'h0); wait_done(lat, f, rd, p);
        checks++; if (rd !== 32'h000000BB) begin errors++; $display("FAIL ldrb_u got %h want 000000bb", rd); end
        checks++; if (lat !== 2 || f !== 1'b0) begin errors++; $display("FAIL ldrb_lat got %0d/%b want 2/0", lat, f); end
        checks++; if (rd_cnt - r0 !== 1 || last_raddr !== 32'h100) begin
            errors++; $display("FAIL ldrb_rd got %0d@%h want 1@00000100", rd_cnt - r0, last_raddr); end
        checks++; if (p !== 1'b0) begin errors++; $display("FAIL ldrb_pulse got %b want 0", p); end
        issue(1'b0, 4'b0001, 1'b1, 32'h102, 32'h0); wait_done(lat, f, rd, p);
        checks++; if (rd !== 32'hFFFFFFBB) begin errors++; $display("FAIL ldrb_s got %h want ffffffbb", rd); end
    endtask

    task automatic test_load_half;
        int lat; logic f, p; logic [31:0] rd;
        mem[32'h200 >> 2] = 32'h80011234;
        issue(1'b0, 4'b0011, 1'b1, 32'h202, 32'h0); wait_done(lat, f, rd, p);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL ldrsh got %h want ffff8001", rd); end
        issue(1'b0, 4'b0011, 1'b0, 32'h202, 32'h0); wait_done(lat, f, rd, p);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL ldrh got %h want 00008001", rd); end
        issue(1'b0, 4'b0011, 1'b1, 32'h200, 32'h0); wait_done(lat, f, rd, p);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL ldrsh_lo got %h want 00001234", rd); end
        issue(1'b0, 4'b1111, 1'b1, 32'h200, 32'h0); wait_done(lat, f, rd, p);
        checks++; if (rd !== 32'h80011234 || lat !== 2) begin errors++; $display("FAIL ldr got %h/%0d want 80011234/2", rd, lat); end
        issue(1'b0, 4'b0001, 1'b1, 32'h203, 32'h0); wait_done(lat, f, rd, p);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL ldrsb_b3 got %h want ffffff80", rd); end
    endtask

    task automatic test_store_partial;
        int lat, r0, w0; logic f, p; logic [31:0] rd;
        mem[32'h300 >> 2] = 32'h11223344;
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b1, 4'b0001, 1'b0, 32'h301, 32'h77777755); wait_done(lat, f, rd, p);
        checks++; if (last_wdata !== 32'h11225544 || last_waddr !== 32'h300) begin
            errors++; $display("FAIL strb_word got %h@%h want 11225544@00000300", last_wdata, last_waddr); end
        checks++; if (lat !== 3 || f !== 1'b0) begin errors++; $display("FAIL strb_lat got %0d/%b want 3/0", lat, f); end
        checks++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin
            errors++; $display("FAIL strb_ops got rd%0d wr%0d want rd1 wr1", rd_cnt - r0, wr_cnt - w0); end
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL strb_keep_rd got %h want ffffff80", rd); end
        mem[32'h300 >> 2] = 32'h11225544;
        issue(1'b1, 4'b0011, 1'b1, 32'h302, 32'h9999ABCD); wait_done(lat, f, rd, p);
        checks++; if (last_wdata !== 32'hABCD5544) begin errors++; $display("FAIL strh_word got %h want abcd5544", last_wdata); end
    endtask

    task automatic test_store_word;
        int lat, r0, w0; logic f, p; logic [31:0] rd;
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b1, 4'b1111, 1'b0, 32'h400, 32'hDEADBEEF); wait_done(lat, f, rd, p);
        checks++; if (last_wdata !== 32'hDEADBEEF || last_waddr !== 32'h400) begin
            errors++; $display("FAIL str_word got %h@%h want deadbeef@00000400", last_wdata, last_waddr); end
        checks++; if (lat !== 2 || rd_cnt - r0 !== 0 || wr_cnt - w0 !== 1) begin
            errors++; $display("FAIL str_ops got lat%0d rd%0d wr%0d want lat2 rd0 wr1", lat, rd_cnt - r0, wr_cnt - w0); end
    endtask

    task automatic test_misalign;
        int lat, q0; logic f, p; logic [31:0] rd;
        logic [3:0]  bes [3] = '{4'b0011, 4'b0110, 4'b1111};
        logic [31:0] ads [3] = '{32'h501, 32'h500, 32'h402};
        for (int i = 0; i < 3; i++) begin
            q0 = req_cnt;
            issue(1'b0, bes[i], 1'b0, ads[i], 32'h0); wait_done(lat, f, rd, p);
            checks++; if (lat !== 1 || f !== 1'b1 || req_cnt !== q0) begin
                errors++; $display("FAIL misalign%0d got lat%0d f%b req%0d want lat1 f1 req0", i, lat, f, req_cnt - q0); end
            checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL misalign%0d_rd got %h want ffffff80", i, rd); end
        end
    endtask

    task automatic test_timeout;
        int lat, q0; logic f, p; logic [31:0] rd;
        ack_en = 1'b0; q0 = req_cnt;
        issue(1'b0, 4'b1111, 1'b0, 32'h100, 32'h0); wait_done(lat, f, rd, p);
        checks++; if (lat < 0 || f !== 1'b1) begin errors++; $display("FAIL tout_fault got lat%0d f%b want fault", lat, f); end
        checks++; if (req_cnt - q0 < TO || req_cnt - q0 > TO + 1) begin
            errors++; $display("FAIL tout_len got %0d want %0d..%0d", req_cnt - q0, TO, TO + 1); end
        checks++; if (bus.mem_req !== 1'b0 || rd !== 32'hFFFFFF80) begin
            errors++; $display("FAIL tout_after got req%b rd%h want req0 rd ffffff80", bus.mem_req, rd); end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        int lat, w0; logic f, p; logic [31:0] rd;
        ack_en = 1'b0; w0 = wr_cnt;
        issue(1'b1, 4'b0001, 1'b0, 32'h301, 32'h55);
        @(posedge clk); #1;
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b want 1", bus.mem_req); end
        #2 reset = 1'b1; #1;
        checks++; if ({bus.mem_req, bus.mem_we, bus.membusy} !== 3'b000) begin
            errors++; $display("FAIL rmid_async got %b want 000", {bus.mem_req, bus.mem_we, bus.membusy}); end
        ack_en = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (wr_cnt !== w0 || bus.readdata !== 32'h0) begin
            errors++; $display("FAIL rmid_after got wr%0d rd%h want wr0 rd0", wr_cnt - w0, bus.readdata); end
        issue(1'b0, 4'b1111, 1'b0, 32'h100, 32'h0); wait_done(lat, f, rd, p);
        checks++; if (rd !== 32'hAABBCCDD || lat !== 2) begin errors++; $display("FAIL rmid_load got %h/%0d want aabbccdd/2", rd, lat); end
    endtask

    initial begin
        errors = 0; checks = 0; rd_cnt = 0; wr_cnt = 0; req_cnt = 0;
        last_raddr = '0; last_waddr = '0; last_wdata = '0;
        ack_en = 1'b1; reset = 1'b1;
        bus.memreq = 1'b0; bus.memw = 1'b0; bus.byteenable = 4'b0; bus.signedld = 1'b0;
        bus.adr = '0; bus.writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        reset = 1'b0;
        @(posedge clk); #1;
        test_load_byte;
        test_load_half;
        test_store_partial;
        test_store_word;
        test_misalign;
        test_timeout;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
